// File: rtl/stage_controller.sv
// Game sequencer: IDLE -> CLEAR -> RUN -> INTER ... -> WON/LOST, restarted by a start rising edge.
// Every output is decoded from registered state, so inputs act one cycle later; there is no backpressure.
module stage_controller #(
    parameter int INTER_FRAMES = 60
) (
    input  logic       Clock,
    input  logic       resetn,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       stage_1_car_done,
    input  logic       stage_2_car_done,
    input  logic       stage_3_car_done,
    input  logic       game_over_feedback,
    input  logic       clear_done,
    output logic       stage_1_in_progress,
    output logic       stage_2_in_progress,
    output logic       stage_3_in_progress,
    output logic       cars_resetn,
    output logic       clear_req,
    output logic [1:0] current_stage,
    output logic       game_won,
    output logic       game_lost
);

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, INTER, WON, LOST} state_t;

    localparam logic [7:0] ICNT_LAST = 8'(INTER_FRAMES - 1);

    state_t     state, state_nxt;
    logic [1:0] stage, stage_nxt;
    logic [7:0] icnt, icnt_nxt;
    logic       start_q;
    logic       start_rise;
    logic       stage_done;

    assign start_rise = start & ~start_q;

    // Only the done line of the stage currently being played counts.
    always_comb begin
        stage_done = 1'b0;
        case (stage)
            2'd1:    stage_done = stage_1_car_done;
            2'd2:    stage_done = stage_2_car_done;
            2'd3:    stage_done = stage_3_car_done;
            default: stage_done = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!resetn) begin
            state   <= IDLE;
            stage   <= 2'd0;
            icnt    <= 8'd0;
            start_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            stage   <= stage_nxt;
            icnt    <= icnt_nxt;
            start_q <= start;
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage;
        icnt_nxt  = icnt;
        case (state)
            IDLE, WON, LOST: begin
                if (start_rise) begin
                    state_nxt = CLEAR;
                    stage_nxt = 2'd1;
                end
            end
            CLEAR: begin
                if (clear_done)
                    state_nxt = RUN;
            end
            RUN: begin
                // A loss outranks a simultaneous stage completion.
                if (game_over_feedback) begin
                    state_nxt = LOST;
                end else if (stage_done) begin
                    if (stage == 2'd3) begin
                        state_nxt = WON;
                    end else begin
                        state_nxt = INTER;
                        icnt_nxt  = 8'd0;
                    end
                end
            end
            INTER: begin
                if (frame_tick) begin
                    if (icnt == ICNT_LAST) begin
                        state_nxt = CLEAR;
                        stage_nxt = stage + 2'd1;
                        icnt_nxt  = 8'd0;
                    end else begin
                        icnt_nxt = icnt + 8'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stage_1_in_progress = (state == RUN) && (stage == 2'd1);
    assign stage_2_in_progress = (state == RUN) && (stage == 2'd2);
    assign stage_3_in_progress = (state == RUN) && (stage == 2'd3);
    // Cars are held in reset everywhere except while a stage or its intermission is live.
    assign cars_resetn         = (state == RUN) || (state == INTER);
    assign clear_req           = (state == CLEAR);
    assign current_stage       = stage;
    assign game_won            = (state == WON);
    assign game_lost           = (state == LOST);

endmodule

// File: tb/tb_stage_controller.sv
// Bench for stage_controller: directed game scenarios then random play, checked against a phase-level model.
module tb_stage_controller;

    localparam int INTER_FRAMES = 3;

    logic       Clock = 1'b0;
    logic       resetn, start, frame_tick, clear_done, game_over_feedback;
    logic       stage_1_car_done, stage_2_car_done, stage_3_car_done;
    logic       stage_1_in_progress, stage_2_in_progress, stage_3_in_progress;
    logic       cars_resetn, clear_req, game_won, game_lost;
    logic [1:0] current_stage;
    logic [9:0] dut_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: game phase as text, stage number, ticks seen in this intermission.
    string ph = "IDLE";
    int    mstage = 0;
    int    ticks = 0;
    bit    mprev_start = 1'b0;

    stage_controller #(.INTER_FRAMES(INTER_FRAMES)) dut (
        .Clock               (Clock),
        .resetn              (resetn),
        .start               (start),
        .frame_tick          (frame_tick),
        .stage_1_car_done    (stage_1_car_done),
        .stage_2_car_done    (stage_2_car_done),
        .stage_3_car_done    (stage_3_car_done),
        .game_over_feedback  (game_over_feedback),
        .clear_done          (clear_done),
        .stage_1_in_progress (stage_1_in_progress),
        .stage_2_in_progress (stage_2_in_progress),
        .stage_3_in_progress (stage_3_in_progress),
        .cars_resetn         (cars_resetn),
        .clear_req           (clear_req),
        .current_stage       (current_stage),
        .game_won            (game_won),
        .game_lost           (game_lost)
    );

    always #10 Clock = ~Clock;

    assign dut_out = {stage_1_in_progress, stage_2_in_progress, stage_3_in_progress,
                      cars_resetn, clear_req, current_stage, game_won, game_lost};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (phase %s stage %0d)", tag, got, exp, ph, mstage);
        end
    endtask

    function automatic bit cur_done();
        case (mstage)
            1:       return stage_1_car_done;
            2:       return stage_2_car_done;
            3:       return stage_3_car_done;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        bit rise;
        rise = start && !mprev_start;
        if (!resetn) begin
            ph = "IDLE"; mstage = 0; ticks = 0; mprev_start = 1'b0;
            return;
        end
        mprev_start = start;
        if (ph == "IDLE" || ph == "WON" || ph == "LOST") begin
            if (rise) begin ph = "CLEAR"; mstage = 1; end
        end else if (ph == "CLEAR") begin
            if (clear_done) ph = "RUN";
        end else if (ph == "RUN") begin
            if (game_over_feedback) ph = "LOST";
            else if (cur_done()) begin
                if (mstage == 3) ph = "WON";
                else begin ph = "INTER"; ticks = 0; end
            end
        end else if (ph == "INTER") begin
            if (frame_tick) begin
                ticks++;
                if (ticks == INTER_FRAMES) begin ph = "CLEAR"; mstage++; end
            end
        end
    endtask

    function automatic logic [9:0] model_out();
        bit run;
        run = (ph == "RUN");
        return {run && mstage == 1, run && mstage == 2, run && mstage == 3,
                ph == "RUN" || ph == "INTER", ph == "CLEAR", 2'(mstage),
                ph == "WON", ph == "LOST"};
    endfunction

    task automatic step(input string tag);
        model_step();
        @(posedge Clock);
        #1;
        check(tag, dut_out, model_out());
    endtask

    task automatic set_done(input int n, input logic v);
        case (n)
            1:       stage_1_car_done = v;
            2:       stage_2_car_done = v;
            default: stage_3_car_done = v;
        endcase
    endtask

    task automatic press_start();
        start = 1'b0; step("start_low");
        start = 1'b1; step("start_rise");
        check("start_clear_req", clear_req, 1);
        start = 1'b0;
    endtask

    task automatic enter_run(input int n);
        clear_done = 1'b1; step("clear_done");
        clear_done = 1'b0;
        check("run_stage", current_stage, n);
        check("run_cars_resetn", cars_resetn, 1);
    endtask

    task automatic finish_stage(input int n);
        set_done(n, 1'b1); step("stage_done");
        set_done(n, 1'b0);
    endtask

    // Intermission with game_over raised on every tick, which must be ignored.
    task automatic intermission(input int ticks_wanted);
        for (int t = 0; t < ticks_wanted; t++) begin
            frame_tick = 1'b1; game_over_feedback = 1'b1; step("inter_tick");
            frame_tick = 1'b0; game_over_feedback = 1'b0; step("inter_gap");
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; frame_tick = 1'b0; clear_done = 1'b0;
        game_over_feedback = 1'b0;
        stage_1_car_done = 1'b0; stage_2_car_done = 1'b0; stage_3_car_done = 1'b0;

        step("reset0");
        step("reset1");
        check("reset_outputs", dut_out, 10'd0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            {stage_1_car_done, stage_2_car_done, stage_3_car_done, game_over_feedback} = 4'($urandom);
            frame_tick = 1'($urandom_range(0, 1));
            step("idle_noise");
        end
        check("idle_stage", current_stage, 0);
        {stage_1_car_done, stage_2_car_done, stage_3_car_done, game_over_feedback, frame_tick} = 5'd0;

        // Full win, with wrong-stage done pulses and ignored game_over in intermissions.
        press_start();
        for (int n = 1; n <= 3; n++) begin
            enter_run(n);
            set_done((n % 3) + 1, 1'b1); step("wrong_stage_done");
            set_done((n % 3) + 1, 1'b0);
            check("wrong_done_still_run", clear_req, 0);
            if (n == 3) start = 1'b1;
            finish_stage(n);
            if (n < 3) begin
                intermission(INTER_FRAMES);
                check("inter_next_stage", current_stage, n + 1);
                check("inter_clear_req", clear_req, 1);
            end
        end
        check("won_flag", game_won, 1);
        check("won_stage", current_stage, 3);
        check("won_cars_resetn", cars_resetn, 0);
        for (int i = 0; i < 4; i++) step("won_start_held");
        check("won_hold", game_won, 1);
        press_start();
        check("restart_stage", current_stage, 1);

        // Loss wins over a simultaneous done in stage 2.
        enter_run(1);
        finish_stage(1);
        intermission(INTER_FRAMES);
        enter_run(2);
        game_over_feedback = 1'b1; stage_2_car_done = 1'b1; step("loss_priority");
        game_over_feedback = 1'b0; stage_2_car_done = 1'b0;
        check("lost_flag", game_lost, 1);
        check("lost_stage", current_stage, 2);

        // Reset two ticks into an intermission.
        press_start();
        enter_run(1);
        finish_stage(1);
        intermission(2);
        resetn = 1'b0; frame_tick = 1'b1; step("midrun_reset");
        check("midrun_reset_outputs", dut_out, 10'd0);
        resetn = 1'b1; frame_tick = 1'b0;
        press_start();
        enter_run(1);
        finish_stage(1);
        intermission(INTER_FRAMES);
        check("post_reset_inter_len", current_stage, 2);

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            resetn             = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) start = ~start;
            frame_tick         = ($urandom_range(0, 1) == 0);
            clear_done         = ($urandom_range(0, 2) == 0);
            stage_1_car_done   = ($urandom_range(0, 5) == 0);
            stage_2_car_done   = ($urandom_range(0, 5) == 0);
            stage_3_car_done   = ($urandom_range(0, 5) == 0);
            game_over_feedback = ($urandom_range(0, 24) == 0);
            step("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
